alu_share_arbiter: RTL and testbench

//  Shares one aluN instance between two requesters (e.g. main datapath and a

---
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external aluN between two requesters. Round-robin arbitration
//   over valid/ready handshakes, operand/op steering to the ALU, and a
//   one-entry registered response slot tagged with the issuing requester.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   req0_* / req1_*            requester handshakes, operands and ops
//                              (op: 00 add, 01 sub, 10 and, 11 or)
//   SrcA, SrcB, ALUControl     drive the external ALU
//   ALUResult                  combinational result back from the ALU
//   rsp_valid/ready/data/id    response slot handshake, result and requester id
module alu_share_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic [N-1:0] SrcA,
  output logic [N-1:0] SrcB,
  output logic [1:0]   ALUControl,
  input  logic [N-1:0] ALUResult,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_id
);

  typedef enum logic {StEmpty, StFull} slot_state_e;

  slot_state_e  r_state;
  logic [N-1:0] r_rsp_data;
  logic         r_rsp_id;
  logic         r_last_grant;

  logic w_slot_free;
  logic w_gnt0;
  logic w_gnt1;

  // The slot can take a new result when empty or when it is being drained now.
  assign w_slot_free = (r_state == StEmpty) || rsp_ready;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_slot_free) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Idle ALU is fed add 0+0.
  always_comb begin
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = 2'b00;
    if (w_gnt0) begin
      SrcA       = req0_a;
      SrcB       = req0_b;
      ALUControl = req0_op;
    end else if (w_gnt1) begin
      SrcA       = req1_a;
      SrcB       = req1_b;
      ALUControl = req1_op;
    end
  end

  // A grant implies the requester is valid, so grant == accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StEmpty;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_gnt0 || w_gnt1) begin
            r_state      <= StFull;
            r_rsp_data   <= ALUResult;
            r_rsp_id     <= w_gnt1;
            r_last_grant <= w_gnt1;
          end
        end
        StFull: begin
          if (w_gnt0 || w_gnt1) begin
            // Drain and reload on the same edge: no bubble.
            r_rsp_data   <= ALUResult;
            r_rsp_id     <= w_gnt1;
            r_last_grant <= w_gnt1;
          end else if (rsp_ready) begin
            r_state <= StEmpty;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign rsp_valid = (r_state == StFull);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic [N-1:0] SrcA, SrcB, ALUResult;
  logic [1:0]   ALUControl;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] rsp_data;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   alu_f = a + b;
      2'b01:   alu_f = a - b;
      2'b10:   alu_f = a & b;
      default: alu_f = a | b;
    endcase
  endfunction

  // Stand-in for the external aluN.
  always_comb ALUResult = alu_f(SrcA, SrcB, ALUControl);

  int total = 0;
  int bad   = 0;

  // Reference model state: what the slot must hold, and who won last.
  bit           m_valid;
  logic [N-1:0] m_data;
  bit           m_id;
  bit           m_last;

  logic cap_r0, cap_r1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare mid-cycle, advance model past the edge.
  task automatic step(input bit v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                      input logic [1:0] op0, input bit v1, input logic [N-1:0] a1,
                      input logic [N-1:0] b1, input logic [1:0] op1, input bit rr,
                      input bit rst);
    bit free;
    int win;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready = rr;
    reset = rst;
    #4;
    free = !m_valid || rr;
    win = -1;
    if (free) begin
      if (v0 && v1) win = m_last ? 0 : 1;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(win == 0));
    chk("req1_ready", 32'(req1_ready), 32'(win == 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("SrcA", 32'(SrcA), 32'(win == 0 ? a0 : (win == 1 ? a1 : '0)));
    chk("SrcB", 32'(SrcB), 32'(win == 0 ? b0 : (win == 1 ? b1 : '0)));
    chk("ALUControl", 32'(ALUControl), 32'(win == 0 ? op0 : (win == 1 ? op1 : 2'b00)));
    cap_r0 = req0_ready;
    cap_r1 = req1_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_data = '0; m_id = 0; m_last = 1;
    end else if (win >= 0) begin
      m_valid = 1;
      m_data  = (win == 0) ? alu_f(a0, b0, op0) : alu_f(a1, b1, op1);
      m_id    = (win == 1);
      m_last  = (win == 1);
    end else if (free) begin
      m_valid = 0;
    end
  endtask

  task automatic idle(input bit rr);
    step(0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 2'b00, rr, 0);
  endtask

  logic [N-1:0] held_data;
  bit           held_id;

  initial begin
    reset = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 0;
    @(posedge clk);
    #1;
    m_valid = 0; m_data = '0; m_id = 0; m_last = 1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);

    // T1
    step(1, 8'h05, 8'h03, 2'b00, 0, 8'h00, 8'h00, 2'b00, 1, 0);
    chk("t1_ready0", 32'(cap_r0), 32'd1);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'h08);
    chk("t1_id", 32'(rsp_id), 32'd0);
    idle(1);

    // T2: fresh reset so the first tie goes to requester 0
    step(0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 2'b00, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h10, 8'h01, 2'b01, 1, 8'hF0, 8'h0F, 2'b11, 1, 0);
      chk("t2_id", 32'(rsp_id), 32'(i % 2));
      chk("t2_data", 32'(rsp_data), (i % 2 == 0) ? 32'h0F : 32'hFF);
      chk("t2_valid", 32'(rsp_valid), 32'd1);
    end

    // T3: last grant was 1; slot full, consumer stalls
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h01, 8'h01, 2'b00, 1, 8'h02, 8'h02, 2'b00, 0, 0);
      chk("t3_ready0", 32'(cap_r0), 32'd0);
      chk("t3_ready1", 32'(cap_r1), 32'd0);
      chk("t3_data_held", 32'(rsp_data), 32'(held_data));
      chk("t3_id_held", 32'(rsp_id), 32'(held_id));
    end
    step(1, 8'h01, 8'h01, 2'b00, 1, 8'h02, 8'h02, 2'b00, 1, 0);
    chk("t3_release_ready0", 32'(cap_r0), 32'd1);
    chk("t3_release_data", 32'(rsp_data), 32'h02);
    idle(1);

    // T4
    step(0, 8'h00, 8'h00, 2'b00, 1, 8'hFF, 8'h01, 2'b00, 1, 0);
    chk("t4_add_wrap", 32'(rsp_data), 32'h00);
    step(1, 8'h00, 8'h01, 2'b01, 0, 8'h00, 8'h00, 2'b00, 1, 0);
    chk("t4_sub_wrap", 32'(rsp_data), 32'hFF);
    step(1, 8'hAA, 8'h0F, 2'b10, 0, 8'h00, 8'h00, 2'b00, 1, 0);
    chk("t4_and", 32'(rsp_data), 32'h0A);

    // T5: slot full, req1 accepted in the reset cycle
    step(0, 8'h00, 8'h00, 2'b00, 1, 8'h33, 8'h11, 2'b00, 1, 1);
    chk("t5_valid", 32'(rsp_valid), 32'd0);
    chk("t5_data", 32'(rsp_data), 32'd0);
    step(1, 8'h04, 8'h04, 2'b00, 1, 8'h07, 8'h07, 2'b00, 1, 0);
    chk("t5_tie_ready0", 32'(cap_r0), 32'd1);
    chk("t5_tie_data", 32'(rsp_data), 32'h08);

    // T6
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 8'h00, 2'b00, 1, 8'(i), 8'h10, 2'b00, 1, 0);
      chk("t6_ready1", 32'(cap_r1), 32'd1);
      chk("t6_data", 32'(rsp_data), 32'(8'h10 + 8'(i)));
    end
    step(1, 8'h01, 8'h02, 2'b11, 1, 8'h05, 8'h06, 2'b11, 1, 0);
    chk("t6_tie_ready0", 32'(cap_r0), 32'd1);
    chk("t6_tie_data", 32'(rsp_data), 32'h03);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2'($urandom),
           bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
